multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 38 +++
 rtl/ctrl_decode.sv | 39 +++
 rtl/multicycle_ctrl.sv | 141 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control path.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc  = 2'd2;

    // Per-instruction controls latched when DECODE is left.
    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       imm_sel;
        logic       alu_src;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CtrlNone = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the per-instruction control bundle.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       legal_o,
    output ctrl_t      ctrl_o
);

    always_comb begin
        legal_o = 1'b1;
        ctrl_o  = CtrlNone;
        case (opcode_i)
            OpR: ;
            OpI: ctrl_o.alu_src = 1'b1;
            OpLoad: begin
                ctrl_o.is_load = 1'b1;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.wb_sel  = WbMem;
            end
            OpStore: begin
                ctrl_o.is_store = 1'b1;
                ctrl_o.alu_src  = 1'b1;
            end
            OpBranch: ctrl_o.is_branch = 1'b1;
            OpJal: begin
                ctrl_o.is_jal  = 1'b1;
                ctrl_o.imm_sel = 1'b1;
                ctrl_o.wb_sel  = WbPc;
            end
            OpLui: begin
                ctrl_o.imm_sel = 1'b1;
                ctrl_o.alu_src = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback with memory
// acknowledge timeouts, a sticky trap state and a retired-instruction counter.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned Inst_Size   = 32,
    parameter int unsigned Mem_Timeout = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 br_taken,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_rd,
    output logic                 dmem_wr,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 wr_en,
    output logic                 Imm_Sel,
    output logic                 jal,
    output logic                 alu_src,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [Inst_Size-1:0] instret
);

    localparam int unsigned WaitW = (Mem_Timeout < 2) ? 1 : $clog2(Mem_Timeout);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(Mem_Timeout - 1);

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [Inst_Size-1:0] instret_q, instret_d;
    ctrl_t                ctrl_q, dec_ctrl;
    logic                 dec_legal;
    logic                 wait_expired;

    // func3 is part of the decoder interface but selects nothing at this level.
    logic unused_func3;
    assign unused_func3 = ^func3;

    ctrl_decode u_decode (
        .opcode_i (opcode),
        .legal_o  (dec_legal),
        .ctrl_o   (dec_ctrl)
    );

    assign wait_expired = (wait_q == WaitLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
            ctrl_q    <= CtrlNone;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            if (state_q == StDecode) begin
                ctrl_q <= dec_ctrl;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        instret_d = instret_q;
        imem_req  = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_en   = 1'b1;
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: state_d = dec_legal ? StExec : StTrap;
            StExec: begin
                if (ctrl_q.is_load || ctrl_q.is_store) begin
                    state_d = StMem;
                end else if (ctrl_q.is_branch) begin
                    pc_en     = 1'b1;
                    pc_sel    = br_taken;
                    instret_d = instret_q + 1'b1;
                    state_d   = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_rd = ctrl_q.is_load;
                dmem_wr = ctrl_q.is_store;
                if (dmem_ack) begin
                    if (ctrl_q.is_load) begin
                        state_d = StWb;
                    end else begin
                        pc_en     = 1'b1;
                        instret_d = instret_q + 1'b1;
                        state_d   = StFetch;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb: begin
                wr_en     = 1'b1;
                pc_en     = 1'b1;
                pc_sel    = ctrl_q.is_jal;
                instret_d = instret_q + 1'b1;
                state_d   = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    assign Imm_Sel = ctrl_q.imm_sel;
    assign jal     = ctrl_q.is_jal;
    assign alu_src = ctrl_q.alu_src;
    assign wb_sel  = ctrl_q.wb_sel;
    assign trap    = (state_q == StTrap);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from
// the instruction's class and ack delays, checked every cycle on the falling edge.
module tb_multicycle_ctrl;

    localparam int W  = 5;
    localparam int TO = 15;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    localparam int PinNone = 0, PinAddWb = 1, PinRet1 = 2, PinLoadWb = 3, PinLoadEnd = 4;
    localparam int PinJalWb = 5, PinBeqExec = 6, PinBeqEnd = 7, PinTrap = 8, PinNoTrap = 9;
    localparam int PinStoreTo = 10, PinMidRst = 11;

    typedef struct {
        logic       rst, imem_ack, dmem_ack, br_taken;
        logic [6:0] opcode;
        logic [2:0] func3;
        bit         chk, chk_ctrl, mon_clr;
        int         pin;
        logic       imem_req, dmem_rd, dmem_wr, ir_en, pc_en, pc_sel, wr_en;
        logic       imm_sel, jal_e, alu_src, trap;
        logic [1:0] wb_sel;
        logic [W-1:0] instret;
    } cyc_t;

    logic clk, rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic br_taken, imem_ack, dmem_ack;
    logic imem_req, dmem_rd, dmem_wr, ir_en, pc_en, pc_sel, wr_en, Imm_Sel, jal, alu_src, trap;
    logic [1:0] wb_sel;
    logic [W-1:0] instret;

    multicycle_ctrl #(.Inst_Size(W), .Mem_Timeout(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .wr_en(wr_en),
        .Imm_Sel(Imm_Sel), .jal(jal), .alu_src(alu_src), .wb_sel(wb_sel), .trap(trap),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cyc_t cyc_plan[$];
    cyc_t cur;
    int   retired;
    bit   after_rst;
    int   total, bad;
    int   wr_cnt, wr_cyc, rd_cnt, dwr_cnt, trap_cnt, cyc_idx;

    function automatic bit legal_op(input logic [6:0] op);
        return op == OpcR || op == OpcI || op == OpcLoad || op == OpcStore ||
               op == OpcBranch || op == OpcJal || op == OpcLui;
    endfunction

    task automatic blank(output cyc_t r);
        r          = '{default: '0};
        r.opcode   = 7'($urandom);
        r.func3    = 3'($urandom);
        r.imem_ack = 1'($urandom_range(1, 0));
        r.dmem_ack = 1'($urandom_range(1, 0));
        r.br_taken = 1'($urandom_range(1, 0));
        r.chk      = 1'b1;
        r.pin      = PinNone;
        r.instret  = W'(retired);
        if (after_rst) begin
            r.chk_ctrl = 1'b1;
            after_rst  = 1'b0;
        end
    endtask

    task automatic set_ctrl(inout cyc_t r, input logic [6:0] op);
        r.chk_ctrl = 1'b1;
        r.imm_sel  = (op == OpcLui || op == OpcJal);
        r.jal_e    = (op == OpcJal);
        r.alu_src  = (op == OpcI || op == OpcLoad || op == OpcStore || op == OpcLui);
        r.wb_sel   = (op == OpcLoad) ? 2'd1 : (op == OpcJal) ? 2'd2 : 2'd0;
    endtask

    task automatic do_reset();
        cyc_t r;
        for (int i = 0; i < 2; i++) begin
            r     = '{default: '0};
            r.rst = 1'b1;
            cyc_plan.push_back(r);
        end
        retired   = 0;
        after_rst = 1'b1;
    endtask

    task automatic add_idle(input int pin);
        cyc_t r;
        blank(r);
        r.imem_ack = 1'b0;
        r.imem_req = 1'b1;
        r.pin      = pin;
        cyc_plan.push_back(r);
    endtask

    task automatic add_trap(input int n, input bit acks);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            blank(r);
            r.trap = 1'b1;
            if (acks) begin
                r.imem_ack = 1'b1;
                r.dmem_ack = 1'b1;
            end
            cyc_plan.push_back(r);
        end
    endtask

    // fw/mw: wait cycles before the imem/dmem ack; TO or more means never acked.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic br,
                         output bit trapped);
        cyc_t r;
        logic ld, st, bq, jl;
        ld = (op == OpcLoad);
        st = (op == OpcStore);
        bq = (op == OpcBranch);
        jl = (op == OpcJal);
        trapped = 1'b0;
        for (int i = 0; i < fw && i < TO; i++) begin
            blank(r);
            r.imem_ack = 1'b0;
            r.imem_req = 1'b1;
            cyc_plan.push_back(r);
        end
        if (fw >= TO) begin
            trapped = 1'b1;
            return;
        end
        blank(r);
        r.imem_ack = 1'b1;
        r.imem_req = 1'b1;
        r.ir_en    = 1'b1;
        cyc_plan.push_back(r);
        blank(r);
        r.opcode = op;
        cyc_plan.push_back(r);
        if (!legal_op(op)) begin
            trapped = 1'b1;
            return;
        end
        blank(r);
        set_ctrl(r, op);
        if (bq) begin
            r.br_taken = br;
            r.pc_en    = 1'b1;
            r.pc_sel   = br;
        end
        cyc_plan.push_back(r);
        if (bq) begin
            retired++;
            return;
        end
        if (ld || st) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                blank(r);
                set_ctrl(r, op);
                r.dmem_ack = 1'b0;
                r.dmem_rd  = ld;
                r.dmem_wr  = st;
                cyc_plan.push_back(r);
            end
            if (mw >= TO) begin
                trapped = 1'b1;
                return;
            end
            blank(r);
            set_ctrl(r, op);
            r.dmem_ack = 1'b1;
            r.dmem_rd  = ld;
            r.dmem_wr  = st;
            r.pc_en    = st;
            cyc_plan.push_back(r);
            if (st) begin
                retired++;
                return;
            end
        end
        blank(r);
        set_ctrl(r, op);
        r.wr_en  = 1'b1;
        r.pc_en  = 1'b1;
        r.pc_sel = jl;
        cyc_plan.push_back(r);
        retired++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        cur = '{default: '0};
        total = 0;
        bad = 0;
        forever begin
            @(negedge clk);
            if (cur.chk) begin
                if (cur.mon_clr) begin
                    wr_cnt = 0; rd_cnt = 0; dwr_cnt = 0; trap_cnt = 0; cyc_idx = 0; wr_cyc = 0;
                end
                cyc_idx++;
                if (wr_en === 1'b1) begin
                    wr_cnt++;
                    wr_cyc = cyc_idx;
                end
                if (dmem_rd === 1'b1) rd_cnt++;
                if (dmem_wr === 1'b1) dwr_cnt++;
                if (trap === 1'b1) trap_cnt++;
                check("imem_req", imem_req, cur.imem_req);
                check("dmem_rd", dmem_rd, cur.dmem_rd);
                check("dmem_wr", dmem_wr, cur.dmem_wr);
                check("ir_en", ir_en, cur.ir_en);
                check("pc_en", pc_en, cur.pc_en);
                check("pc_sel", pc_sel, cur.pc_sel);
                check("wr_en", wr_en, cur.wr_en);
                check("trap", trap, cur.trap);
                check("instret", instret, cur.instret);
                if (cur.chk_ctrl) begin
                    check("imm_sel", Imm_Sel, cur.imm_sel);
                    check("jal", jal, cur.jal_e);
                    check("alu_src", alu_src, cur.alu_src);
                    check("wb_sel", wb_sel, cur.wb_sel);
                end
                case (cur.pin)
                    PinAddWb: begin
                        check("add_wr_count", wr_cnt, 1);
                        check("add_wr_cycle", wr_cyc, 4);
                    end
                    PinRet1: check("add_instret", instret, 1);
                    PinLoadWb: check("load_wb_sel", wb_sel, 1);
                    PinLoadEnd: begin
                        check("load_rd_cycles", rd_cnt, 4);
                        check("load_instret", instret, 1);
                    end
                    PinJalWb: begin
                        check("jal_imm_sel", Imm_Sel, 1);
                        check("jal_jal", jal, 1);
                        check("jal_wb_sel", wb_sel, 2);
                        check("jal_pc_sel", pc_sel, 1);
                    end
                    PinBeqExec: begin
                        check("beq_pc_en", pc_en, 1);
                        check("beq_pc_sel", pc_sel, 1);
                    end
                    PinBeqEnd: begin
                        check("beq_wr_count", wr_cnt, 0);
                        check("beq_instret", instret, 1);
                    end
                    PinTrap: begin
                        check("trap_cycles", trap_cnt, 20);
                        check("trap_held", trap, 1);
                    end
                    PinNoTrap: begin
                        check("trap_cleared", trap, 0);
                        check("fetch_after_rst", imem_req, 1);
                    end
                    PinStoreTo: begin
                        check("store_wait_cycles", dwr_cnt, TO);
                        check("store_timeout_trap", trap, 1);
                    end
                    PinMidRst: begin
                        check("midrst_dmem_wr", dmem_wr, 0);
                        check("midrst_imem_req", imem_req, 1);
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [6:0] legal_ops [7];

    initial begin
        bit   trapped;
        int   i0;
        int   fw, mw;
        logic [6:0] op;
        cyc_t r;

        legal_ops = '{OpcR, OpcI, OpcLoad, OpcStore, OpcBranch, OpcJal, OpcLui};
        rst = 1'b1; opcode = '0; func3 = '0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        retired = 0;
        after_rst = 1'b0;
        repeat (2) @(posedge clk);

        // ADD: F, D, E, WB with wr_en in cycle 4
        do_reset();
        i0 = cyc_plan.size();
        build(OpcR, 0, 0, 1'b0, trapped);
        cyc_plan[i0].mon_clr = 1'b1;
        cyc_plan[cyc_plan.size() - 1].pin = PinAddWb;
        add_idle(PinRet1);

        // LOAD with ack after three wait cycles
        do_reset();
        i0 = cyc_plan.size();
        build(OpcLoad, 0, 3, 1'b0, trapped);
        cyc_plan[i0].mon_clr = 1'b1;
        cyc_plan[cyc_plan.size() - 1].pin = PinLoadWb;
        add_idle(PinLoadEnd);

        // JAL
        do_reset();
        build(OpcJal, 0, 0, 1'b0, trapped);
        cyc_plan[cyc_plan.size() - 1].pin = PinJalWb;
        add_idle(PinNone);

        // BEQ taken
        do_reset();
        i0 = cyc_plan.size();
        build(OpcBranch, 1, 0, 1'b1, trapped);
        cyc_plan[i0].mon_clr = 1'b1;
        cyc_plan[cyc_plan.size() - 1].pin = PinBeqExec;
        add_idle(PinBeqEnd);

        // Illegal opcode, acks hammered while trapped, then reset
        do_reset();
        build(7'b1111111, 0, 0, 1'b0, trapped);
        i0 = cyc_plan.size();
        add_trap(20, 1'b1);
        cyc_plan[i0].mon_clr = 1'b1;
        cyc_plan[cyc_plan.size() - 1].pin = PinTrap;
        do_reset();
        add_idle(PinNoTrap);

        // STORE never acknowledged
        do_reset();
        i0 = cyc_plan.size();
        build(OpcStore, 0, TO, 1'b0, trapped);
        cyc_plan[i0].mon_clr = 1'b1;
        add_trap(1, 1'b0);
        cyc_plan[cyc_plan.size() - 1].pin = PinStoreTo;

        // STORE interrupted by reset in its fifth MEM cycle
        do_reset();
        i0 = cyc_plan.size();
        build(OpcStore, 0, TO, 1'b0, trapped);
        while (cyc_plan.size() > i0 + 8) void'(cyc_plan.pop_back());
        cyc_plan[i0 + 7].rst = 1'b1;
        retired   = 0;
        after_rst = 1'b1;
        add_idle(PinMidRst);

        // Randomized instruction stream
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(24, 0) == 0) begin
                op = 7'($urandom);
                while (legal_op(op)) op = 7'($urandom);
            end else begin
                op = legal_ops[$urandom_range(6, 0)];
            end
            fw = ($urandom_range(19, 0) == 0) ? TO - 1 : int'($urandom_range(3, 0));
            mw = ($urandom_range(39, 0) == 0) ? TO :
                 ($urandom_range(14, 0) == 0) ? TO - 1 : int'($urandom_range(3, 0));
            build(op, fw, mw, 1'($urandom_range(1, 0)), trapped);
            if (trapped) begin
                add_trap(3, 1'b0);
                do_reset();
            end
        end

        while (cyc_plan.size() > 0) begin
            r = cyc_plan.pop_front();
            @(posedge clk);
            #1;
            rst      = r.rst;
            opcode   = r.opcode;
            func3    = r.func3;
            br_taken = r.br_taken;
            imem_ack = r.imem_ack;
            dmem_ack = r.dmem_ack;
            cur      = r;
        end
        @(posedge clk);
        #1;
        cur.chk = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
